// File: rtl/multiplier_stream_adapter.sv
// Valid/ready stream front-end for the sequential multiplier.
// Buffers operand pairs, runs one job at a time, streams products out.
module multiplier_stream_adapter #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_multiplicand,
  input  logic [N-1:0]                 in_multiplier,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*N-1:0]               out_product,
  output logic                         mul_start,
  input  logic                         mul_ready,
  output logic [N-1:0]                 mul_multiplicand,
  output logic [N-1:0]                 mul_multiplier,
  input  logic [2*N-1:0]               mul_product,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DRAIN
  } state_t;

  state_t state;

  logic [2*N-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [2*N-1:0] head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  // Extra pointer MSB separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && !empty &&
                      mul_ready && !out_valid;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_level = LW'(wr_ptr - rd_ptr);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_multiplicand, in_multiplier};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      out_valid        <= 1'b0;
      out_product      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            mul_multiplicand <= head[2*N-1:N];
            mul_multiplier   <= head[N-1:0];
            mul_start        <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mul_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mul_ready) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mul_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multiplier_stream_adapter.md
# multiplier_stream_adapter

Valid/ready stream front-end for the sequential multiplier. Buffers operand pairs in a small FIFO, launches one multiplication at a time through the multiplier's start/ready handshake, and returns each 2N-bit product on a valid/ready output stream. Sits directly between the operand producer and the multiplier, and also collects the multiplier's product.

## Interface
- N, 4: operand width in bits; must match the attached multiplier.
- DEPTH, 4: operand FIFO entries; power of two, ≥ 2.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  = FIFO not full (combinational from the level).
- in_multiplicand  in  N  operand A.
- in_multiplier  in  N  operand B.
- out_valid  out  1  out_product holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2N  result, A*B unsigned.
- mul_start  out  1  to multiplier start; one-cycle pulse.
- mul_ready  in  1  from multiplier ready.
- mul_multiplicand  out  N  to multiplier multiplicand; registered.
- mul_multiplier  out  N  to multiplier multiplier; registered.
- mul_product  in  2N  from multiplier product.
- fifo_level  out  $clog2(DEPTH+1)  entries currently buffered.

## Operation
- Reset (async assert): FIFO empty, fifo_level=0, in_ready=1, out_valid=0, out_product=0, mul_start=0, mul_multiplicand=0, mul_multiplier=0, state=IDLE. Any in-flight job and buffered operands are discarded.
- Push: in_valid&&in_ready at an edge writes {A,B} at the tail. Pop: the IDLE→START transition only.
- Push and pop on the same edge are legal (level unchanged). No bypass: when the FIFO is full, in_ready=0 even if a pop occurs that edge.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full/empty come from the MSB compare.
- FSM:
  - IDLE: if FIFO non-empty && mul_ready && !out_valid, pop the head into mul_multiplicand/mul_multiplier and go to START.
  - START: mul_start=1 for exactly this cycle → WAIT_BUSY.
  - WAIT_BUSY: stay until mul_ready=0, then → WAIT_DONE.
  - WAIT_DONE: on mul_ready=1, load out_product←mul_product, set out_valid=1, → DRAIN.
  - DRAIN: on out_valid&&out_ready, clear out_valid → IDLE. out_product holds its last value.
- mul_multiplicand and mul_multiplier stay stable from the pop edge until the next pop.
- Results leave in FIFO order, one per job. No result is dropped or duplicated under out_ready backpressure.
- Operand width rule: product is the full 2N-bit unsigned value; no truncation or saturation.

## Timing
- Push at edge 0 with FIFO empty and multiplier idle:
  - edge 1: IDLE→START.
  - cycle 1–2: mul_start high.
  - edge 2: →WAIT_BUSY.
- Multiplier busy time is not assumed; the adapter waits on the mul_ready edges only.
- out_valid rises on the edge after mul_ready is sampled high in WAIT_DONE.
- Minimum gap between consecutive mul_start pulses: start, busy, done, one DRAIN cycle with out_ready=1, one IDLE cycle.
- mul_start never asserts while mul_ready=0 or while out_valid=1.
- Reset deassertion: first push is possible on the first edge after reset_n rises.

## Test plan
- Single job: push A=3,B=5 with out_ready=1 → exactly one mul_start pulse; out_product=15 with out_valid for one cycle; fifo_level returns to 0.
- Full-range operands: push A=15,B=15 and A=0,B=9 → out_product 225 then 0, in order.
- FIFO fill: hold out_ready=0 and push 6 pairs (i, i+1) for i=1..6.
  - 1st pair launches; 2nd–5th buffer; fifo_level reaches 4; in_ready=0; 6th stalls until a pop.
  - Then out_ready=1 → products 2,6,12,20,30,42 in order.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_product stable, no new mul_start. Raising out_ready → next job launches within 2 cycles.
- Simultaneous push/pop at level=2 on the IDLE→START edge → fifo_level stays 2; in_ready=1.
- Reset mid-operation: assert reset_n=0 in WAIT_DONE with 3 entries buffered → immediately out_valid=0, mul_start=0, fifo_level=0, in_ready=1. After release, no stale product emerges.
